// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light interval timer: debounce FSM
// encodings and default parameter values.
package traffic_pkg;

  typedef enum logic [1:0] {
    StLo     = 2'd0,
    StPendHi = 2'd1,
    StHi     = 2'd2,
    StPendLo = 2'd3
  } db_state_e;

  localparam int unsigned DefPrescale   = 1000;
  localparam int unsigned DefShortTicks = 5;
  localparam int unsigned DefLongTicks  = 25;
  localparam int unsigned DefDbCycles   = 16;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..PRESCALE-1 and flags the last count as a one-cycle tick.
// clr restarts the count from zero at the edge it is sampled.
module tick_gen
  import traffic_pkg::*;
#(
  parameter int unsigned PRESCALE = DefPrescale
) (
  input  logic clk,
  input  logic R,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0] Last = W'(PRESCALE - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr || (cnt_q == Last)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == Last);

endmodule

// File: rtl/interval_timer.sv
// Short/long interval timer with car-sensor conditioning. Define
// TIMER_SENSOR_DEBOUNCE_EN to build the sensor debounce FSM; otherwise C is the synchronized CS.
module interval_timer
  import traffic_pkg::*;
#(
  parameter int unsigned PRESCALE    = DefPrescale,
  parameter int unsigned SHORT_TICKS = DefShortTicks,
  parameter int unsigned LONG_TICKS  = DefLongTicks,
  parameter int unsigned DB_CYCLES   = DefDbCycles
) (
  input  logic clk,
  input  logic R,
  input  logic IC,
  input  logic CS,
  output logic S,
  output logic L,
  output logic C
);

  if (PRESCALE < 2 || SHORT_TICKS < 1 || LONG_TICKS <= SHORT_TICKS || DB_CYCLES < 2)
  begin : g_param_err
    $error("interval_timer: illegal parameter combination");
  end

  localparam int unsigned CW = $clog2(LONG_TICKS + 1);
  localparam logic [CW-1:0] ShortVal = CW'(SHORT_TICKS);
  localparam logic [CW-1:0] LongVal  = CW'(LONG_TICKS);

  logic          tick;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic          s_q, l_q;

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk (clk),
    .R   (R),
    .clr (IC),
    .tick(tick)
  );

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (IC) begin
      tick_cnt_d = '0;
    end else if (tick && (tick_cnt_q != LongVal)) begin
      tick_cnt_d = tick_cnt_q + CW'(1);
    end
  end

  // S/L follow the next counter value so they move on the same edge as the count.
  always_ff @(posedge clk) begin
    if (R) begin
      tick_cnt_q <= '0;
      s_q        <= 1'b0;
      l_q        <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      s_q        <= (tick_cnt_d >= ShortVal);
      l_q        <= (tick_cnt_d == LongVal);
    end
  end

  assign S = s_q;
  assign L = l_q;

  logic sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (R) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= CS;
      sync2_q <= sync1_q;
    end
  end

`ifdef TIMER_SENSOR_DEBOUNCE_EN
  localparam int unsigned HW = $clog2(DB_CYCLES + 1);
  localparam logic [HW-1:0] HoldLast = HW'(DB_CYCLES - 1);

  db_state_e     state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          c_q;

  // The entering sample counts as the first of the DB_CYCLES consecutive samples.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      StLo: begin
        if (sync2_q) begin
          state_d = StPendHi;
          hold_d  = HW'(1);
        end
      end
      StPendHi: begin
        if (!sync2_q) begin
          state_d = StLo;
        end else if (hold_q == HoldLast) begin
          state_d = StHi;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      StHi: begin
        if (!sync2_q) begin
          state_d = StPendLo;
          hold_d  = HW'(1);
        end
      end
      StPendLo: begin
        if (sync2_q) begin
          state_d = StHi;
        end else if (hold_q == HoldLast) begin
          state_d = StLo;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = StLo;
    endcase
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state_q <= StLo;
      hold_q  <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      c_q     <= (state_d == StHi) || (state_d == StPendLo);
    end
  end

  assign C = c_q;
`else
  assign C = sync2_q;
`endif

endmodule

// File: tb/tb_interval_timer.sv
// Directed self-checking bench for interval_timer (PRESCALE=4, SHORT=2, LONG=5, DB=3).
// Sensor expectations follow TIMER_SENSOR_DEBOUNCE_EN.
module tb_interval_timer;

  logic clk = 1'b0;
  logic R, IC, CS;
  logic S, L, C;

  int n_pass  = 0;
  int n_total = 0;

`ifdef TIMER_SENSOR_DEBOUNCE_EN
  localparam int CLat = 5;
`else
  localparam int CLat = 2;
`endif

  interval_timer #(
    .PRESCALE   (4),
    .SHORT_TICKS(2),
    .LONG_TICKS (5),
    .DB_CYCLES  (3)
  ) dut (
    .clk(clk),
    .R  (R),
    .IC (IC),
    .CS (CS),
    .S  (S),
    .L  (L),
    .C  (C)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Advance n rising edges; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with IC and CS high
    R = 1'b1; IC = 1'b1; CS = 1'b1;
    step(1);
    check("rst_S", 32'(S), 0);
    check("rst_L", 32'(L), 0);
    check("rst_C", 32'(C), 0);
    check("rst_cnt", 32'(dut.tick_cnt_q), 0);
    R = 1'b0; IC = 1'b0; CS = 1'b0;
    step(10);
    check("idle_C", 32'(C), 0);

    // IC pulse then release: S at +8, L at +20, both held
    IC = 1'b1; step(1); IC = 1'b0;
    step(7);
    check("s_before", 32'(S), 0);
    step(1);
    check("s_rise", 32'(S), 1);
    check("l_early", 32'(L), 0);
    step(11);
    check("l_before", 32'(L), 0);
    step(1);
    check("l_rise", 32'(L), 1);
    for (int i = 0; i < 40; i++) begin
      step(1);
      check("sl_hold", 32'({S, L}), 32'h3);
    end

    // IC reasserted at edge 18
    IC = 1'b1; step(1); IC = 1'b0;
    step(17);
    check("mid_S", 32'(S), 1);
    check("mid_L", 32'(L), 0);
    IC = 1'b1; step(1); IC = 1'b0;
    check("reclr_S", 32'(S), 0);
    check("reclr_L", 32'(L), 0);
    for (int i = 19; i <= 37; i++) begin
      step(1);
      check("reclr_l_low", 32'(L), 0);
      if (i == 25) check("reclr_s_before", 32'(S), 0);
      if (i == 26) check("reclr_s_rise", 32'(S), 1);
    end
    step(1);
    check("reclr_l_rise", 32'(L), 1);

    // IC held high 30 cycles
    IC = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step(1);
      check("ic_hold", 32'({S, L}), 0);
    end
    IC = 1'b0;
    step(7);
    check("rel_s_before", 32'(S), 0);
    step(1);
    check("rel_s_rise", 32'(S), 1);

    // Sensor conditioning
`ifdef TIMER_SENSOR_DEBOUNCE_EN
    CS = 1'b1; step(2); CS = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("short_pulse_C", 32'(C), 0);
    end
    CS = 1'b1;
    step(4);
    check("db_c_before", 32'(C), 0);
    step(1);
    check("db_c_rise", 32'(C), 1);
    step(5);
    check("db_c_high", 32'(C), 1);
    CS = 1'b0; step(1); CS = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("glitch_C", 32'(C), 1);
    end
    CS = 1'b0;
    step(4);
    check("db_c_fall_before", 32'(C), 1);
    step(1);
    check("db_c_fall", 32'(C), 0);
`else
    CS = 1'b1;
    step(1);
    check("raw_c_before", 32'(C), 0);
    step(1);
    check("raw_c_rise", 32'(C), 1);
    CS = 1'b0; step(1);
    check("raw_glitch_e1", 32'(C), 1);
    CS = 1'b1; step(1);
    check("raw_glitch_e2", 32'(C), 0);
    step(1);
    check("raw_glitch_e3", 32'(C), 1);
`endif

    // Reset mid-operation, then restart timing
    CS = 1'b1;
    IC = 1'b1; step(1); IC = 1'b0;
    step(25);
    check("pre_rst", 32'({S, L, C}), 32'h7);
    R = 1'b1; IC = 1'b1;
    step(1);
    check("mid_rst_SLC", 32'({S, L, C}), 0);
    check("mid_rst_cnt", 32'(dut.tick_cnt_q), 0);
    R = 1'b0; IC = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      check("post_rst_S", 32'(S), (i >= 8) ? 1 : 0);
      check("post_rst_C", 32'(C), (i >= CLat) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/interval_timer.md
INTERVAL_TIMER -- requirements
Module: interval_timer

Interface
REQ-001 SHALL have parameter PRESCALE, default 1000, meaning clk cycles per timer tick (>=2).
REQ-002 SHALL have parameter SHORT_TICKS, default 5, meaning ticks until S asserts (>=1).
REQ-003 SHALL have parameter LONG_TICKS, default 25, meaning ticks until L asserts (>SHORT_TICKS).
REQ-004 SHALL have parameter DB_CYCLES, default 16, meaning clk cycles a sensor level must hold before C follows it (>=2).
REQ-005 SHALL have port clk input 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port R input 1, the reset: synchronous, active-high.
REQ-007 SHALL have port IC input 1, interval clear from the light controller.
REQ-008 SHALL have port CS input 1, raw asynchronous car-sensor level.
REQ-009 SHALL have port S output 1, short interval elapsed, registered.
REQ-010 SHALL have port L output 1, long interval elapsed, registered.
REQ-011 SHALL have port C output 1, conditioned car-present level, registered.

Function
REQ-012 The prescaler SHALL count 0..PRESCALE-1 and wrap; tick is high for the one cycle where the prescaler equals PRESCALE-1.
REQ-013 The tick counter SHALL increment on each tick while IC=0 and SHALL saturate at LONG_TICKS; its width is $clog2(LONG_TICKS+1).
REQ-014 IC=1 sampled at an edge SHALL clear the prescaler, the tick counter, S and L at that edge; IC wins over a simultaneous tick.
REQ-015 IC held high SHALL hold the timer cleared; counting resumes on the first edge with IC=0.
REQ-016 S SHALL update at the same edge as the tick counter: S=1 at the edge the counter reaches SHORT_TICKS, L=1 at the edge it reaches LONG_TICKS; both stay high until IC or R.
REQ-017 Latency: with IC released, S SHALL rise exactly PRESCALE*SHORT_TICKS edges and L exactly PRESCALE*LONG_TICKS edges after the last edge sampling IC=1.
REQ-018 CS SHALL pass a 2-flop synchronizer before any use; C never depends on CS combinationally.
REQ-019 The conditioning FSM SHALL have states LO, PEND_HI, HI, PEND_LO; C=1 in HI and PEND_LO, C=0 otherwise.
REQ-020 Transitions: LO->PEND_HI on sync=1; PEND_HI->HI after DB_CYCLES consecutive sync=1, ->LO on any sync=0; HI->PEND_LO on sync=0; PEND_LO->LO after DB_CYCLES consecutive sync=0, ->HI on any sync=1; the hold counter restarts on every PEND entry.
REQ-021 IC SHALL have no effect on the conditioning FSM.

Reset
REQ-022 R=1 at an edge SHALL set prescaler=0, counter=0, S=0, L=0, synchronizer flops=0, FSM=LO, C=0; R overrides IC and tick.
REQ-023 R asserted mid-interval or mid-debounce SHALL abandon the operation; after release timing restarts as if IC had just been released.

Configuration
REQ-024 With TIMER_SENSOR_DEBOUNCE_EN defined, the FSM of REQ-019/020 SHALL be built.
REQ-025 Without TIMER_SENSOR_DEBOUNCE_EN, C SHALL equal the second synchronizer flop (2-cycle latency from CS) and DB_CYCLES is unused.

Structure
REQ-026 FSM state encodings (LO=2'd0, PEND_HI=2'd1, HI=2'd2, PEND_LO=2'd3) and default parameter values SHALL live in shared package traffic_pkg.
REQ-027 The prescaler SHALL be sub-module tick_gen (ports clk, R, clr, tick); all else stays in interval_timer.

Verification (PRESCALE=4, SHORT_TICKS=2, LONG_TICKS=5, DB_CYCLES=3)
REQ-028 R=1 one edge with IC=1, CS=1 -> S=L=C=0 next cycle, counter=0.
REQ-029 IC pulse 1 cycle then low -> S rises at edge 8, L at edge 20 after the IC edge; both hold 40 further cycles.
REQ-030 IC reasserted at edge 18 (S=1, L=0) -> S=0 at that edge; L never rises before edge 18+20.
REQ-031 IC held high 30 cycles -> S=L=0 throughout; release -> S at +8 edges.
REQ-032 CS high 2 cycles then low (debounce on) -> C stays 0; CS high 10 cycles -> C rises at 2+3 edges after CS rises; CS 1-cycle low glitch -> C stays 1.
REQ-033 Debounce off: CS 0->1 -> C=1 two edges later; 1-cycle glitch propagates to C.
